// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared definitions for the instruction-memory program loader.
//                Holds the default frame header byte and the loader FSM
//                state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

  // Default frame header byte.
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Loader FSM states, explicitly 3 bits wide.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LEN  = 3'd2,
    ST_HI   = 3'd3,
    ST_LO   = 3'd4,
    ST_CSUM = 3'd5,
    ST_DONE = 3'd6,
    ST_ERR  = 3'd7
  } state_t;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Program loader placed in front of the instruction memory.
//                Receives a framed byte stream over a valid/ready handshake:
//                  SYNC, N, N x {hi, lo}, CSUM (XOR of all 2N payload bytes)
//                Each {hi, lo} pair is written to instruction memory one cycle
//                after the lo byte is accepted. The processor is held via
//                cpu_hold from the start of a load until a frame completes
//                with a good checksum.
//  Ports       :
//    clk        in   system clock, rising edge
//    rst        in   asynchronous active-low reset
//    start      in   1-cycle pulse, begin or restart a load
//    rx_data    in   incoming byte
//    rx_valid   in   rx_data valid
//    rx_ready   out  loader accepts a byte (transfer = rx_valid & rx_ready)
//    im_we      out  instruction memory write strobe, 1 cycle per word
//    im_addr    out  instruction memory write address
//    im_wdata   out  instruction memory write data {hi, lo}
//    cpu_hold   out  processor must stall
//    done       out  sticky: last frame loaded with good checksum
//    err        out  sticky: last frame rejected
//    word_count out  words written in the current/last frame
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W  = 6,
  parameter int         INSTR_W = 16,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               err,
  output logic [ADDR_W:0]    word_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef logic [ADDR_W:0] cnt_t;
  localparam cnt_t CNT_ONE = cnt_t'(1);

  state_t     state;
  state_t     state_next;
  logic       xfer;
  logic [7:0] csum;
  logic [7:0] hi_byte;
  cnt_t       len;
  logic       len_bad;
  cnt_t       count_inc;

  assign xfer      = rx_valid & rx_ready;
  assign count_inc = word_count + CNT_ONE;

  // N must be 1..DEPTH so the write address can never wrap.
  assign len_bad = (rx_data == 8'd0) || ({24'd0, rx_data} > DEPTH);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. start overrides everything, including a byte
  // transferred in the same cycle (that byte is consumed and dropped).
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ST_HDR;
    end else begin
      case (state)
        ST_HDR:  if (xfer) state_next = (rx_data == SYNC) ? ST_LEN : ST_ERR;
        ST_LEN:  if (xfer) state_next = len_bad ? ST_ERR : ST_HI;
        ST_HI:   if (xfer) state_next = ST_LO;
        ST_LO:   if (xfer) state_next = (count_inc == len) ? ST_CSUM : ST_HI;
        ST_CSUM: if (xfer) state_next = (rx_data == csum) ? ST_DONE : ST_ERR;
        ST_DONE: state_next = ST_IDLE;
        default: state_next = state;   // IDLE and ERR wait for start
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    rx_ready = 1'b0;
    case (state)
      ST_HDR, ST_LEN, ST_HI, ST_LO, ST_CSUM: rx_ready = 1'b1;
      default:                              rx_ready = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: byte assembly, checksum, memory write port and status flags.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      csum       <= 8'd0;
      hi_byte    <= 8'd0;
      len        <= '0;
    end else begin
      im_we <= 1'b0;
      if (start) begin
        cpu_hold   <= 1'b1;
        done       <= 1'b0;
        err        <= 1'b0;
        word_count <= '0;
        csum       <= 8'd0;
      end else begin
        if (xfer) begin
          case (state)
            ST_LEN: len <= cnt_t'(rx_data);  // only used when in range
            ST_HI: begin
              hi_byte <= rx_data;
              csum    <= csum ^ rx_data;
            end
            ST_LO: begin
              csum       <= csum ^ rx_data;
              im_we      <= 1'b1;
              im_addr    <= word_count[ADDR_W-1:0];
              im_wdata   <= {hi_byte, rx_data};
              word_count <= count_inc;
            end
            default: ;
          endcase
        end
        if (state == ST_CSUM && state_next == ST_DONE) begin
          done <= 1'b1;
        end
        if (state != ST_ERR && state_next == ST_ERR) begin
          err <= 1'b1;
        end
        // Release the processor as the FSM returns to IDLE after success.
        if (state == ST_DONE) begin
          cpu_hold <= 1'b0;
        end
      end
    end
  end

endmodule : imem_loader
`default_nettype wire
